// File: rtl/onchip_ram_pkg.sv
// Shared constants, byte-merge helper and parameter checks for the dual-port on-chip RAM.

`ifndef ONCHIP_RAM_PARAM_CHECK
// Elaboration-time guard on the two structural parameters every variant depends on.
`define ONCHIP_RAM_PARAM_CHECK(lat, dw) \
  if (!(((lat) == 1) || ((lat) == 2))) begin : gen_bad_read_latency \
    $error("onchip_ram: READ_LATENCY must be 1 or 2"); \
  end \
  if (((dw) % 8) != 0) begin : gen_bad_data_width \
    $error("onchip_ram: DATA_WIDTH must be a multiple of 8"); \
  end
`endif

package onchip_ram_pkg;

  // Cross-port same-address read-during-write result.
  localparam string RdwNew = "NEW";
  localparam string RdwOld = "OLD";

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int unsigned MaxDataWidth = 1024;
  localparam int unsigned MaxBytes     = MaxDataWidth / 8;

  // Enabled lanes come from new_word, all other lanes keep old_word.
  function automatic logic [MaxDataWidth-1:0] byte_merge(
    input logic [MaxDataWidth-1:0] old_word,
    input logic [MaxDataWidth-1:0] new_word,
    input logic [MaxBytes-1:0]     byteenable
  );
    logic [MaxDataWidth-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MaxBytes; b++) begin
      if (byteenable[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Storage array: two byte-enabled write ports and two synchronous read ports.
// Callers must only enable an access whose index is inside the array and must
// keep the two write ports on disjoint lanes when they hit the same word.

module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16000,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter string       INIT_FILE  = "onchip_ram.hex"
) (
  input  logic                                clk_i,
  input  logic [1:0]                          we_i,
  input  logic [1:0]                          re_i,
  input  logic [1:0][ADDR_WIDTH-1:0]          addr_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]        be_i,
  input  logic [1:0][DATA_WIDTH-1:0]          wdata_i,
  output logic [1:0][DATA_WIDTH-1:0]          rdata_o
);

  if (INIT_FILE == "") begin : gen_no_init
    $info("onchip_ram_core: no INIT_FILE given, power-up contents are undefined");
  end

  // Preloaded by the RAM inference flow from INIT_FILE; never cleared by reset.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane writes and read-before-write synchronous reads on both ports.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 2; p++) begin
      if (we_i[p]) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
          if (be_i[p][b]) begin
            mem_q[addr_i[p]][b*8 +: 8] <= wdata_i[p][b*8 +: 8];
          end
        end
      end
      if (re_i[p]) begin
        rdata_o[p] <= mem_q[addr_i[p]];
      end
    end
  end

endmodule

// File: rtl/onchip_ram_dp_pipelined.sv
// True dual-port on-chip RAM with two Avalon-MM slaves and pipelined reads.
// Owns accept gating, cross-port collision/forwarding and the read-valid pipeline.

module onchip_ram_dp_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 16000,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       RDW_MODE     = "NEW",
  parameter string       INIT_FILE    = "onchip_ram.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          RdwIsNew = (RDW_MODE == RdwNew);

  `ONCHIP_RAM_PARAM_CHECK(READ_LATENCY, DATA_WIDTH)

  if ((RDW_MODE != RdwNew) && (RDW_MODE != RdwOld)) begin : gen_bad_rdw_mode
    $error("onchip_ram: RDW_MODE must be \"NEW\" or \"OLD\"");
  end
  if (DATA_WIDTH > MaxDataWidth) begin : gen_bad_wide_data
    $error("onchip_ram: DATA_WIDTH exceeds the byte-merge helper width");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH)) begin : gen_bad_addr_width
    $error("onchip_ram: ADDR_WIDTH too small for DEPTH");
  end

  // Port bundles, index 0 = s1, index 1 = s2.
  logic [1:0]                 cs, rd_req, wr_req;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][NumBytes-1:0]   be;
  logic [1:0][DATA_WIDTH-1:0] wdata;

  assign cs     = {s2_chipselect, s1_chipselect};
  assign rd_req = {s2_read, s1_read};
  assign wr_req = {s2_write, s1_write};
  assign addr   = {s2_address, s1_address};
  assign be     = {s2_byteenable, s1_byteenable};
  assign wdata  = {s2_writedata, s1_writedata};

  logic                       acc, same_addr, collide;
  logic [1:0]                 in_range, wr_en, rd_en, core_re, fwd;
  logic [1:0][IdxWidth-1:0]   core_addr;
  logic [1:0][NumBytes-1:0]   core_be;
  logic [1:0][DATA_WIDTH-1:0] core_rdata;

  // Accept decode, dual-write lane arbitration and cross-port forwarding select.
  always_comb begin
    acc       = clken & ~reset_req & ~reset;
    same_addr = (addr[0] == addr[1]);
    for (int p = 0; p < 2; p++) begin
      in_range[p]  = (32'(addr[p]) < DEPTH);
      wr_en[p]     = acc & cs[p] & wr_req[p] & in_range[p];
      rd_en[p]     = acc & cs[p] & rd_req[p] & ~wr_req[p];
      core_re[p]   = rd_en[p] & in_range[p];
      core_addr[p] = addr[p][IdxWidth-1:0];
    end
    collide    = wr_en[0] & wr_en[1] & same_addr;
    // s1 owns overlapping lanes, so s2 only writes the lanes s1 leaves alone.
    core_be[0] = be[0];
    core_be[1] = collide ? (be[1] & ~be[0]) : be[1];
    // A reader never writes in the same cycle, so the other port's raw lanes are final.
    fwd[0] = RdwIsNew & core_re[0] & wr_en[1] & same_addr;
    fwd[1] = RdwIsNew & core_re[1] & wr_en[0] & same_addr;
  end

  onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (IdxWidth),
    .INIT_FILE  (INIT_FILE)
  ) u_core (
    .clk_i   (clk),
    .we_i    (wr_en),
    .re_i    (core_re),
    .addr_i  (core_addr),
    .be_i    (core_be),
    .wdata_i (wdata),
    .rdata_o (core_rdata)
  );

  logic [1:0]                 valid1_q, zero_q, fwd_q;
  logic [1:0][DATA_WIDTH-1:0] fwd_data_q;
  logic [1:0][NumBytes-1:0]   fwd_be_q;
  logic [1:0][DATA_WIDTH-1:0] data1, rdata_out;
  logic [1:0]                 rvalid_out;

  // First read stage control; zero_q starts set so readdata reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid1_q <= '0;
      zero_q   <= '1;
      fwd_q    <= '0;
    end else begin
      valid1_q <= rd_en;
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          zero_q[p] <= ~in_range[p];
          fwd_q[p]  <= fwd[p];
        end
      end
    end
  end

  // Forwarded write word, only consulted when fwd_q is set.
  always_ff @(posedge clk) begin
    if (fwd[0]) begin
      fwd_data_q[0] <= wdata[1];
      fwd_be_q[0]   <= be[1];
    end
    if (fwd[1]) begin
      fwd_data_q[1] <= wdata[0];
      fwd_be_q[1]   <= be[0];
    end
  end

  // First-stage read word: zero for out-of-range, merged for forwarded, else array data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (zero_q[p]) begin
        data1[p] = '0;
      end else if (fwd_q[p]) begin
        data1[p] = DATA_WIDTH'(byte_merge(MaxDataWidth'(core_rdata[p]),
                                          MaxDataWidth'(fwd_data_q[p]),
                                          MaxBytes'(fwd_be_q[p])));
      end else begin
        data1[p] = core_rdata[p];
      end
    end
  end

  if (READ_LATENCY == 1) begin : gen_lat1
    assign rvalid_out = valid1_q;
    assign rdata_out  = data1;
  end else begin : gen_lat2
    logic [1:0]                 valid2_q;
    logic [1:0][DATA_WIDTH-1:0] data2_q;

    // Extra output stage; loads only on a valid word so readdata holds otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid2_q <= '0;
        data2_q  <= '0;
      end else begin
        valid2_q <= valid1_q;
        for (int p = 0; p < 2; p++) begin
          if (valid1_q[p]) begin
            data2_q[p] <= data1[p];
          end
        end
      end
    end

    assign rvalid_out = valid2_q;
    assign rdata_out  = data2_q;
  end

  assign s1_readdata      = rdata_out[0];
  assign s1_readdatavalid = rvalid_out[0];
  assign s2_readdata      = rdata_out[1];
  assign s2_readdatavalid = rvalid_out[1];

endmodule

// File: tb/tb_onchip_ram_dp_pipelined.sv
// Bench for onchip_ram_dp_pipelined: two instances (latency 1 / "NEW", latency 2 / "OLD")
// share one stimulus stream and are checked against a word-array model with timed
// expectation queues.

module tb_onchip_ram_dp_pipelined;

  localparam int unsigned Depth = 64;
  localparam int unsigned AW    = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clken, reset_req;
  logic        cs [2];
  logic        rd [2];
  logic        wr [2];
  logic [AW-1:0] addr [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];
  logic [31:0] rdata [2][2];
  logic        rvalid [2][2];

  onchip_ram_dp_pipelined #(
    .DATA_WIDTH(32), .DEPTH(Depth), .ADDR_WIDTH(AW), .READ_LATENCY(1),
    .RDW_MODE("NEW"), .INIT_FILE("onchip_ram.hex")
  ) u_dut_l1_new (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]),
    .s1_readdata(rdata[0][0]), .s1_readdatavalid(rvalid[0][0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]),
    .s2_readdata(rdata[0][1]), .s2_readdatavalid(rvalid[0][1])
  );

  onchip_ram_dp_pipelined #(
    .DATA_WIDTH(32), .DEPTH(Depth), .ADDR_WIDTH(AW), .READ_LATENCY(2),
    .RDW_MODE("OLD"), .INIT_FILE("onchip_ram.hex")
  ) u_dut_l2_old (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]),
    .s1_readdata(rdata[1][0]), .s1_readdatavalid(rvalid[1][0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]),
    .s2_readdata(rdata[1][1]), .s2_readdatavalid(rvalid[1][1])
  );

  typedef struct {
    int          d;
    int          p;
    longint      due;
    logic [31:0] data;
  } exp_t;

  logic [31:0] mem_m [Depth];
  exp_t        expq [$];
  longint      cyc = 0;
  logic [31:0] hold_exp [2][2];
  logic [31:0] last_seen [2][2];
  int          pulses [2][2];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // Apply one clock edge to the model: queue expected reads, then commit writes.
  task automatic model_step();
    bit acc;
    bit inr [2];
    bit wre [2];
    bit rde [2];
    logic [31:0] old_v, new_v;
    exp_t e;
    cyc++;
    if (reset) begin
      expq.delete();
      for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) hold_exp[d][p] = '0;
      return;
    end
    acc = clken && !reset_req;
    for (int p = 0; p < 2; p++) begin
      inr[p] = (addr[p] < Depth);
      wre[p] = acc && cs[p] && wr[p] && inr[p];
      rde[p] = acc && cs[p] && rd[p] && !wr[p];
    end
    for (int p = 0; p < 2; p++) begin
      if (rde[p]) begin
        int q;
        q = 1 - p;
        old_v = inr[p] ? mem_m[addr[p][5:0]] : 32'h0;
        new_v = old_v;
        if (inr[p] && wre[q] && (addr[q] == addr[p])) new_v = merge(old_v, wd[q], be[q]);
        e.d = 0; e.p = p; e.due = cyc;     e.data = new_v; expq.push_back(e);
        e.d = 1; e.p = p; e.due = cyc + 1; e.data = old_v; expq.push_back(e);
      end
    end
    // s1 applied last so it owns any overlapping lanes.
    if (wre[1]) mem_m[addr[1][5:0]] = merge(mem_m[addr[1][5:0]], wd[1], be[1]);
    if (wre[0]) mem_m[addr[0][5:0]] = merge(mem_m[addr[0][5:0]], wd[0], be[0]);
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        int idx;
        bit has;
        idx = -1;
        for (int i = 0; i < expq.size(); i++) begin
          if (idx < 0 && expq[i].d == d && expq[i].p == p) idx = i;
        end
        // An overdue entry was already reported as a missing valid; drop it.
        while (idx >= 0 && expq[idx].due < cyc) begin
          expq.delete(idx);
          idx = -1;
          for (int i = 0; i < expq.size(); i++) begin
            if (idx < 0 && expq[i].d == d && expq[i].p == p) idx = i;
          end
        end
        has = (idx >= 0) && (expq[idx].due == cyc);
        check($sformatf("valid dut%0d s%0d cyc%0d", d, p + 1, cyc),
              32'(rvalid[d][p]), 32'(has));
        if (rvalid[d][p] === 1'b1) begin
          pulses[d][p]++;
          last_seen[d][p] = rdata[d][p];
        end
        if (has) begin
          check($sformatf("data dut%0d s%0d cyc%0d", d, p + 1, cyc),
                rdata[d][p], expq[idx].data);
          hold_exp[d][p] = expq[idx].data;
          expq.delete(idx);
        end else begin
          check($sformatf("hold dut%0d s%0d cyc%0d", d, p + 1, cyc),
                rdata[d][p], hold_exp[d][p]);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle_ports();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
      addr[p] = '0; be[p] = 4'h0; wd[p] = '0;
    end
  endtask

  task automatic set_wr(input int p, input int a, input logic [3:0] b, input logic [31:0] d);
    cs[p] = 1'b1; wr[p] = 1'b1; rd[p] = 1'b0;
    addr[p] = AW'(a); be[p] = b; wd[p] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0;
    addr[p] = AW'(a); be[p] = 4'hF;
  endtask

  initial begin
    int pc0, pc1;
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    idle_ports();
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
      hold_exp[d][p] = '0; last_seen[d][p] = '0; pulses[d][p] = 0;
    end
    for (int i = 0; i < Depth; i++) mem_m[i] = '0;
    repeat (3) step();
    reset = 1'b0;

    // Preload every word through both ports.
    for (int a = 0; a < 32; a++) begin
      set_wr(0, a, 4'hF, 32'hC0DE0000 + 32'(a));
      set_wr(1, a + 32, 4'hF, 32'h5EED0000 + 32'(a));
      step();
    end
    set_wr(0, 0, 4'hF, 32'h11); set_wr(1, 1, 4'hF, 32'h22); step();
    set_wr(0, 2, 4'hF, 32'h33); set_wr(1, 3, 4'hF, 32'h44); step();
    set_wr(0, 32'h20, 4'hF, 32'hAABBCCDD); set_wr(1, 32'h30, 4'hF, 32'hF0000000); step();

    // Basic write then read.
    idle_ports(); set_wr(0, 32'h10, 4'hF, 32'hDEADBEEF); step();
    idle_ports(); set_rd(0, 32'h10); step();
    idle_ports(); step(); step();
    check("basic_l1", last_seen[0][0], 32'hDEADBEEF);
    check("basic_l2", last_seen[1][0], 32'hDEADBEEF);

    // Back-to-back reads on s2.
    pc0 = pulses[0][1]; pc1 = pulses[1][1];
    for (int a = 0; a < 4; a++) begin set_rd(1, a); step(); end
    idle_ports(); repeat (3) step();
    check("b2b_pulses_l1", 32'(pulses[0][1] - pc0), 32'd4);
    check("b2b_pulses_l2", 32'(pulses[1][1] - pc1), 32'd4);
    check("b2b_last_l2", last_seen[1][1], 32'h44);

    // Cross-port read-during-write.
    set_wr(0, 32'h20, 4'h3, 32'h11223344); set_rd(1, 32'h20); step();
    idle_ports(); step(); step();
    check("rdw_new", last_seen[0][1], 32'hAABB3344);
    check("rdw_old", last_seen[1][1], 32'hAABBCCDD);

    // Dual-write collision.
    set_wr(0, 32'h30, 4'h3, 32'h01020304); set_wr(1, 32'h30, 4'h6, 32'hF0F0F0F0); step();
    idle_ports(); set_rd(0, 32'h30); step();
    idle_ports(); step(); step();
    check("collide_l1", last_seen[0][0], 32'hF0F00304);
    check("collide_l2", last_seen[1][0], 32'hF0F00304);

    // Gating: no valid with clken low or reset_req high.
    pc0 = pulses[0][0]; pc1 = pulses[1][0];
    clken = 1'b0; set_rd(0, 32'h10); step();
    clken = 1'b1; reset_req = 1'b1; step();
    reset_req = 1'b0; idle_ports(); step(); step();
    check("gate_l1", 32'(pulses[0][0] - pc0), 32'd0);
    check("gate_l2", 32'(pulses[1][0] - pc1), 32'd0);

    // Out-of-range write must not alias word 0; out-of-range read returns zero.
    set_wr(0, Depth, 4'hF, 32'hBAD0BAD0); step();
    idle_ports(); set_rd(0, 0); set_rd(1, Depth); step();
    idle_ports(); step(); step();
    check("oor_write_l1", last_seen[0][0], 32'h11);
    check("oor_write_l2", last_seen[1][0], 32'h11);
    check("oor_read_l1", last_seen[0][1], 32'h0);
    check("oor_read_l2", last_seen[1][1], 32'h0);

    // Reset one cycle after a read accept: latency-2 read is discarded.
    pc1 = pulses[1][0];
    set_rd(0, 32'h10); step();
    idle_ports(); reset = 1'b1; step();
    reset = 1'b0; step();
    check("rst_no_valid_l2", 32'(pulses[1][0] - pc1), 32'd0);
    check("rst_zero_l2", rdata[1][0], 32'h0);
    check("rst_zero_l1", rdata[0][0], 32'h0);
    set_rd(0, 32'h10); step();
    idle_ports(); step(); step();
    check("rst_retain_l1", last_seen[0][0], 32'hDEADBEEF);
    check("rst_retain_l2", last_seen[1][0], 32'hDEADBEEF);

    // Random traffic, biased toward a few words to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < 2; p++) begin
        cs[p]   = ($urandom_range(0, 7) != 0);
        rd[p]   = 1'($urandom_range(0, 1));
        wr[p]   = ($urandom_range(0, 2) == 0);
        addr[p] = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 3))
                                              : AW'($urandom_range(0, Depth + 3));
        be[p]   = 4'($urandom_range(0, 15));
        wd[p]   = $urandom;
      end
      step();
    end
    reset = 1'b0; clken = 1'b1; reset_req = 1'b0;
    idle_ports(); repeat (4) step();
    check("drain", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onchip_ram_dp_pipelined.md
Name: onchip_ram_dp_pipelined

Overview:
Parametrised true dual-port on-chip RAM with two Avalon-MM slaves, s1 and s2, and pipelined reads with readdatavalid.
- Generalises the team's single-port on-chip memory in width, depth and read latency.
- Adds cross-port read-during-write forwarding and write-collision resolution.
- Sits on the Nios system interconnect as program/data memory, with s2 shared with a DMA or video master.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
DEPTH, 16000, number of words
ADDR_WIDTH, 14, address width; must satisfy 2**ADDR_WIDTH >= DEPTH
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2
RDW_MODE, "NEW", cross-port same-address read-during-write result; "NEW" or "OLD"
INIT_FILE, "onchip_ram.hex", power-up contents; simulation and synthesis preload only

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
clken  in  1  global accept enable
reset_req  in  1  reset-request guard; blocks new accepts
s1_address / s2_address  in  ADDR_WIDTH  word address
s1_chipselect / s2_chipselect  in  1  port select
s1_read / s2_read  in  1  read request
s1_write / s2_write  in  1  write request
s1_byteenable / s2_byteenable  in  DATA_WIDTH/8  byte lanes
s1_writedata / s2_writedata  in  DATA_WIDTH  write data
s1_readdata / s2_readdata  out  DATA_WIDTH  read data
s1_readdatavalid / s2_readdatavalid  out  1  one-cycle read-data strobe

Behaviour:
- Accept gating: acc = clken & ~reset_req & ~reset. Nothing is accepted while acc=0.
- Write: wr_x = acc & chipselect_x & write_x. Write is committed on the same clk edge, bytes limited by byteenable_x.
- Read: rd_x = acc & chipselect_x & read_x & ~write_x. Write wins if both are asserted; the read is dropped and produces no readdatavalid.
- No waitrequest. Each port accepts one command per cycle with unlimited reads in flight, bounded by the pipeline.
- Latency 1: readdata_x and readdatavalid_x are valid the cycle after the accept.
- Latency 2: an additional output register stage adds one cycle.
- readdatavalid_x pulses exactly once per accepted read, in accept order.
- clken and reset_req do not stall the pipeline; in-flight reads drain normally.
- Out of range (address >= DEPTH):
  - writes are ignored, with no array or alias modification;
  - reads return all-zero data with readdatavalid asserted normally.
- Cross-port same address in the same cycle, one port writing and the other reading:
  - RDW_MODE "NEW": the read returns byte-merged data. Enabled lanes come from the writer; the other lanes come from the old contents.
  - RDW_MODE "OLD": the read returns the pre-write word.
- Both ports writing the same address in the same cycle:
  - overlapping byte lanes take the s1 data;
  - non-overlapping lanes from both ports are written.
- Same-port read after write (next cycle) always returns the new data.
- Reset:
  - readdata_x = 0, readdatavalid_x = 0, all pipeline valid bits cleared;
  - memory contents are retained, with no re-initialisation from INIT_FILE;
  - reads in flight when reset asserts are discarded and never produce readdatavalid;
  - the first accept is possible on the first cycle with reset = 0.
- readdata_x holds its last value when readdatavalid_x = 0. Consumers sample only on valid.

Decomposition:
- Package onchip_ram_pkg:
  - RDW_MODE constants;
  - byte-merge function (old, new, byteenable);
  - parameter-check macro for legal READ_LATENCY and DATA_WIDTH % 8 == 0.
- Sub-module onchip_ram_core:
  - storage array with two write ports and two unregistered-address synchronous read ports;
  - INIT_FILE load.
- Top level owns accept gating, collision/forwarding logic, the latency pipeline and valid tracking.

Test Plan:
- Basic read/write, READ_LATENCY=1: s1 writes 0xDEADBEEF at 0x0010 with byteenable 0xF, then reads 0x0010 → s1_readdatavalid one cycle later with 0xDEADBEEF.
- Back-to-back reads, READ_LATENCY=2: s2 reads addresses 0, 1, 2, 3 on consecutive cycles, preloaded 0x11..0x44 → four consecutive valid pulses starting 2 cycles after the first accept, data in order 0x11, 0x22, 0x33, 0x44.
- Cross-port RDW on word 0x0020 (old 0xAABBCCDD):
  - s1 writes 0x11223344 with byteenable 0x3 while s2 reads 0x0020;
  - "NEW" → 0xAABB3344; "OLD" → 0xAABBCCDD.
- Dual-write collision at 0x0030:
  - s1 writes 0x01020304 with byteenable 0x3; s2 writes 0xF0F0F0F0 with byteenable 0x6;
  - reading 0x0030 afterwards → 0xF0F00304.
- Gating and out of range:
  - read with clken=0 or reset_req=1 → no readdatavalid;
  - write to address DEPTH → array unchanged;
  - read of address DEPTH → 0x00000000 with valid.
- Reset mid-flight, READ_LATENCY=2: assert reset one cycle after a read accept → no readdatavalid, readdata = 0, previously written memory data still readable after reset.
